// File: rtl/irq_pkg.sv
// Shared types for the interrupt front end and the 4-to-2 priority encoder wrapper.
package irq_pkg;

  localparam int IRQ_LINES = 4;

  typedef logic [1:0] irq_idx_t;
  typedef logic [3:0] irq_vec_t;

  // Turns an acknowledged index into the single bit it is allowed to clear.
  function automatic irq_vec_t idx_onehot(input irq_idx_t idx);
    return irq_vec_t'(1) << idx;
  endfunction

endpackage

// File: rtl/irq_debounce.sv
// One request line: two-flop synchronizer, debounce counter and rising-edge detect.
module irq_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q;
  logic             s2_q;
  logic             db_q;
  logic             db_d;
  logic             dbPrev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A new level is accepted only after it has been seen on every one of the last N samples.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      db_d  = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      db_q     <= 1'b0;
      dbPrev_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= req_i;
      s2_q     <= s1_q;
      db_q     <= db_d;
      dbPrev_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign rise_o = db_q & ~dbPrev_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky pending latch feeding the priority encoder, with per-line overrun flags.
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic     clk,
  input  logic     rst,
  input  irq_vec_t req_in,
  input  irq_vec_t mask,
  input  logic     ack,
  input  irq_idx_t ack_idx,
  output irq_vec_t pending,
  output logic     any_pending,
  output irq_vec_t overrun
);

  irq_vec_t rise;
  irq_vec_t clr;
  irq_vec_t latched_q;
  irq_vec_t latched_d;
  irq_vec_t overrun_q;
  irq_vec_t overrun_d;

  for (genvar g = 0; g < IRQ_LINES; g++) begin : g_line
    irq_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .req_i (req_in[g]),
      .rise_o(rise[g])
    );
  end

  // A rise beats a same-cycle ack so the new event survives; it only counts as lost
  // when the bit was already pending and nobody is draining it this cycle.
  always_comb begin
    latched_d = latched_q;
    overrun_d = overrun_q;
    clr       = ack ? idx_onehot(ack_idx) : '0;
    for (int i = 0; i < IRQ_LINES; i++) begin
      if (rise[i]) begin
        latched_d[i] = 1'b1;
        if (latched_q[i] && !clr[i]) begin
          overrun_d[i] = 1'b1;
        end
      end else if (clr[i]) begin
        latched_d[i] = 1'b0;
        overrun_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latched_q <= '0;
      overrun_q <= '0;
    end else begin
      latched_q <= latched_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending     = latched_q & mask;
  assign any_pending = |pending;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed vector table, reset sequence and randomized run against a window-based reference model.
module tb_irq_pending_latch;
  import irq_pkg::*;

  localparam int DB = 4;

  logic     clk;
  logic     rst;
  irq_vec_t req_in;
  irq_vec_t mask;
  logic     ack;
  irq_idx_t ack_idx;
  irq_vec_t pending;
  logic     any_pending;
  irq_vec_t overrun;

  int checks;
  int errors;
  bit modelOn;

  typedef struct {
    logic [3:0] req;
    logic [3:0] msk;
    logic       ak;
    logic [1:0] idx;
    int         cycles;
    logic [3:0] expPend;
    logic       expAny;
    logic [3:0] expOvr;
  } vec_t;

  vec_t vecs[$];

  // Reference model state: raw samples taken at each edge, newest first.
  logic [3:0] hist[$];
  logic [3:0] dbM;
  logic [3:0] riseM;
  logic [3:0] latM;
  logic [3:0] ovrM;

  irq_pending_latch #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .mask       (mask),
    .ack        (ack),
    .ack_idx    (ack_idx),
    .pending    (pending),
    .any_pending(any_pending),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic [3:0] r, input logic [3:0] m, input logic a, input logic [1:0] ix,
                        input int n, input logic [3:0] ep, input logic ea, input logic [3:0] eo);
    vec_t v;
    v.req = r; v.msk = m; v.ak = a; v.idx = ix; v.cycles = n;
    v.expPend = ep; v.expAny = ea; v.expOvr = eo;
    vecs.push_back(v);
  endtask

  task automatic modelReset();
    hist.delete();
    dbM = '0; riseM = '0; latM = '0; ovrM = '0;
  endtask

  // The debounced level flips once the synchronized samples (two edges old) have all
  // disagreed with it over the last DB edges; a 0->1 flip latches one edge later.
  task automatic modelStep();
    logic [3:0] riseNow;
    logic [3:0] clrM;
    riseNow = '0;
    clrM    = ack ? (4'b0001 << ack_idx) : 4'b0000;
    hist.push_front(req_in);
    if (hist.size() > DB + 2) void'(hist.pop_back());
    for (int i = 0; i < 4; i++) begin
      if (riseM[i]) begin
        if (latM[i] && !clrM[i]) ovrM[i] = 1'b1;
        latM[i] = 1'b1;
      end else if (clrM[i]) begin
        latM[i] = 1'b0;
        ovrM[i] = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) begin
      bit   allDiff;
      logic v;
      allDiff = 1'b1;
      for (int k = 2; k < DB + 2; k++) begin
        v = (k < hist.size()) ? hist[k][i] : 1'b0;
        if (v == dbM[i]) allDiff = 1'b0;
      end
      if (allDiff) begin
        riseNow[i] = ~dbM[i];
        dbM[i]     = ~dbM[i];
      end
    end
    riseM = riseNow;
  endtask

  task automatic tick();
    @(posedge clk);
    if (modelOn) modelStep();
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] m, input logic a, input logic [1:0] ix);
    req_in  = r;
    mask    = m;
    ack     = a;
    ack_idx = ix;
  endtask

  task automatic checkVal(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] ep, input logic ea, input logic [3:0] eo);
    checkVal({tag, " pending"}, pending, ep);
    checkVal({tag, " any_pending"}, {3'b000, any_pending}, {3'b000, ea});
    checkVal({tag, " overrun"}, overrun, eo);
  endtask

  initial begin
    logic [3:0] reqR;
    checks  = 0;
    errors  = 0;
    modelOn = 1'b0;
    modelReset();
    applyStimulus(4'b0000, 4'b1111, 1'b0, 2'd0);
    rst = 1'b1;
    #1;
    checkOutput("reset", 4'b0000, 1'b0, 4'b0000);
    @(posedge clk);
    #2 rst = 1'b0;

    //        req      mask     ack   idx  n  pending  any   overrun
    addVec(4'b0000, 4'b1111, 1'b0, 2'd0, 3, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b0100, 4'b1111, 1'b0, 2'd0, 3, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b0000, 4'b1111, 1'b0, 2'd0, 8, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b0100, 4'b1111, 1'b0, 2'd0, 7, 4'b0100, 1'b1, 4'b0000);
    addVec(4'b0000, 4'b1111, 1'b1, 2'd2, 1, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b0000, 4'b1111, 1'b0, 2'd0, 8, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b1011, 4'b1111, 1'b0, 2'd0, 6, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b1011, 4'b1111, 1'b0, 2'd0, 1, 4'b1011, 1'b1, 4'b0000);
    addVec(4'b1011, 4'b1111, 1'b1, 2'd3, 1, 4'b0011, 1'b1, 4'b0000);
    addVec(4'b1011, 4'b1111, 1'b1, 2'd1, 1, 4'b0001, 1'b1, 4'b0000);
    addVec(4'b1011, 4'b1111, 1'b1, 2'd0, 1, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b1011, 4'b1111, 1'b0, 2'd0, 5, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b0000, 4'b1111, 1'b0, 2'd0, 8, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b1000, 4'b0111, 1'b0, 2'd0, 7, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b1000, 4'b1111, 1'b0, 2'd0, 0, 4'b1000, 1'b1, 4'b0000);
    addVec(4'b1000, 4'b0111, 1'b1, 2'd3, 1, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b1000, 4'b1111, 1'b0, 2'd0, 0, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b1000, 4'b1111, 1'b1, 2'd2, 1, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b0001, 4'b1111, 1'b0, 2'd0, 7, 4'b0001, 1'b1, 4'b0000);
    addVec(4'b0000, 4'b1111, 1'b0, 2'd0, 7, 4'b0001, 1'b1, 4'b0000);
    addVec(4'b0001, 4'b1111, 1'b0, 2'd0, 7, 4'b0001, 1'b1, 4'b0001);
    addVec(4'b0001, 4'b1111, 1'b1, 2'd0, 1, 4'b0000, 1'b0, 4'b0000);
    addVec(4'b0011, 4'b1111, 1'b0, 2'd0, 7, 4'b0010, 1'b1, 4'b0000);
    addVec(4'b0001, 4'b1111, 1'b0, 2'd0, 7, 4'b0010, 1'b1, 4'b0000);
    addVec(4'b0011, 4'b1111, 1'b0, 2'd0, 6, 4'b0010, 1'b1, 4'b0000);
    addVec(4'b0011, 4'b1111, 1'b1, 2'd1, 1, 4'b0010, 1'b1, 4'b0000);
    addVec(4'b0011, 4'b1111, 1'b0, 2'd0, 1, 4'b0010, 1'b1, 4'b0000);
    addVec(4'b0011, 4'b1111, 1'b1, 2'd1, 1, 4'b0000, 1'b0, 4'b0000);

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].req, vecs[n].msk, vecs[n].ak, vecs[n].idx);
      for (int c = 0; c < vecs[n].cycles; c++) tick();
      #1;
      checkOutput($sformatf("vec%0d", n), vecs[n].expPend, vecs[n].expAny, vecs[n].expOvr);
    end

    // Build up pending bits plus an overrun, then reset asynchronously mid-cycle.
    applyStimulus(4'b1111, 4'b1111, 1'b0, 2'd0);
    for (int c = 0; c < 7; c++) tick();
    checkOutput("preRst latch", 4'b1100, 1'b1, 4'b0000);
    applyStimulus(4'b1011, 4'b1111, 1'b0, 2'd0);
    for (int c = 0; c < 7; c++) tick();
    applyStimulus(4'b1111, 4'b1111, 1'b0, 2'd0);
    for (int c = 0; c < 7; c++) tick();
    checkOutput("preRst overrun", 4'b1100, 1'b1, 4'b0100);
    for (int c = 0; c < 2; c++) tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("midRst", 4'b0000, 1'b0, 4'b0000);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    checkOutput("postRst edge6", 4'b0000, 1'b0, 4'b0000);
    tick();
    checkOutput("postRst edge7", 4'b1111, 1'b1, 4'b0000);

    // Randomized run against the reference model.
    rst = 1'b1;
    modelReset();
    applyStimulus(4'b0000, 4'b1111, 1'b0, 2'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    modelOn = 1'b1;
    reqR = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] m;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) reqR[i] = ~reqR[i];
      m = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
      applyStimulus(reqR, m, ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)));
      #1;
      checkOutput("rand comb", latM & mask, |(latM & mask), ovrM);
      tick();
      #1;
      checkOutput("rand", latM & mask, |(latM & mask), ovrM);
    end
    modelOn = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
